data_read_axi_write: RTL and testbench
======================================

# data_read_axi_write

AXI4-Lite write-channel slave for the data_read peripheral; the counterpart of the peripheral's AXI-Lite read path. It accepts AW/W transfers in any order, updates the control register CR, generates the CR.START and SR.C-clear pulses, and returns a B-channel response. It shares the register map with the read path and supplies the stored CR value so reads of CR return live contents.

## Interface
- C_CR_RESET, 4'b0000, reset value of CR bits [3:0] (bit 0 START is always forced to 0)
- S_AXI_ACLK  in  1  clock; reset S_AXI_ARESETN, asynchronous, active-low; clock S_AXI_ACLK
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  32  write address; only [12:0] decoded
- S_AXI_AWVALID  in  1  address valid
- S_AXI_AWREADY  out  1  address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes; only [0] used
- S_AXI_WVALID  in  1  data valid
- S_AXI_WREADY  out  1  data ready
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID  out  1  response valid
- S_AXI_BREADY  in  1  response accepted
- cr_start  out  1  one-cycle pulse, acquisition start
- cr_enable  out  1  CR.ENABLE level
- cr_mode  out  2  CR.MODE level
- sr_c_clr  out  1  one-cycle pulse, clears SR.C in the status logic
- cr_q  out  32  CR readback: {28'd0, cr_mode, cr_enable, 1'b0}

## Operation
- Register map (offset = AWADDR[12:0]):
  - 0x000 CR: bit 0 START (write-1 pulse, reads 0), bit 1 ENABLE, bits [3:2] MODE.
  - 0x004 SR: writing 1 to bit 0 pulses sr_c_clr; other bits ignored.
  - AWADDR[12:10] in 1..4 is the read-only buffer window: SLVERR, no side effect.
  - Any other offset: OKAY, write discarded.
- If WSTRB[0]=0, CR/SR writes have no effect; the response is still OKAY.
- FSM states (Moore; readies and BVALID decoded from state):
  - IDLE: AWREADY=1, WREADY=1. Both handshakes in the same cycle -> WRITE; AW only -> WAIT_W; W only -> WAIT_A.
  - WAIT_W: WREADY=1. W handshake -> WRITE.
  - WAIT_A: AWREADY=1. AW handshake -> WRITE.
  - WRITE: decode the latched address and data; on exit, update CR, set pulses and BRESP -> RESP.
  - RESP: BVALID=1. BREADY -> IDLE.
- AWADDR is latched on the AW handshake and WDATA/WSTRB on the W handshake. The bus is not re-sampled after the handshake.
- Only one transaction is outstanding at a time. AWREADY and WREADY stay low in WRITE and RESP.

## Timing
- Reset values:
  - State IDLE, so AWREADY=1 and WREADY=1.
  - BVALID=0, BRESP=00.
  - cr_start=0, sr_c_clr=0.
  - cr_enable, cr_mode from C_CR_RESET; cr_q to match.
- Last handshake completes in cycle N (state IDLE/WAIT_*). Cycle N+1 is WRITE. In cycle N+2, BVALID=1 and the new cr_* / pulses are visible.
- cr_start and sr_c_clr are high for exactly one cycle, the first RESP cycle, independent of how long BREADY is held off.
- With BREADY held high, throughput is one write per 3 cycles (IDLE, WRITE, RESP).
- Once BVALID is high, it and BRESP are held stable until BREADY.
- Reset asserted mid-transaction: immediate return to reset values. The partial transaction is dropped and no pulse is emitted.

## Structure
- Shared package data_read_pkg holds:
  - AXI_ADDR_CR / AXI_ADDR_SR offsets, shared with the read path.
  - CR bit positions (START=0, ENABLE=1, MODE=3:2) and the buffer-window decode constants.
  - BRESP codes and the FSM state enumeration.
- No sub-module: a single FSM with address/data latches and the CR register.

## Test plan
- Reset, then AW(0x000) and W(0x0000000F, WSTRB=1) in the same cycle -> BVALID two cycles later with BRESP=00; cr_start pulses once; cr_enable=1, cr_mode=3, cr_q=0x0000000E.
- W(0x1) three cycles before AW(0x004) -> WAIT_A with WREADY=0; after AW, one sr_c_clr pulse and BRESP=00; CR unchanged.
- AW(0x0800) plus W -> BRESP=10, CR unchanged, no pulses; AW(0x1C00) -> BRESP=00, write discarded.
- CR write with WSTRB=4'b1110 -> BRESP=00, CR and pulses unchanged; BREADY held low 5 cycles -> BVALID/BRESP stable, pulse still a single cycle.
- ARESETN asserted while in RESP -> BVALID=0, CR returns to C_CR_RESET, next transaction completes normally.

Source files
------------

// File: rtl/data_read_pkg.sv
// Shared definitions for the data_read peripheral AXI-Lite paths: register
// offsets, CR bit layout, buffer-window decode, BRESP codes and write FSM states.
package data_read_pkg;

    // Register offsets within the 13-bit peripheral address space
    localparam logic [12:0] AXI_ADDR_CR = 13'h000;
    localparam logic [12:0] AXI_ADDR_SR = 13'h004;

    // CR bit positions
    localparam int CR_START_BIT  = 0;
    localparam int CR_ENABLE_BIT = 1;
    localparam int CR_MODE_LO    = 2;
    localparam int CR_MODE_HI    = 3;

    // SR bit that the write path can clear
    localparam int SR_C_BIT = 0;

    // Read-only buffer window: AWADDR[12:10] in BUF_WIN_LO..BUF_WIN_HI
    localparam logic [2:0] BUF_WIN_LO = 3'd1;
    localparam logic [2:0] BUF_WIN_HI = 3'd4;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-channel FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_W = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } wr_state_e;

    // True when the offset falls in the read-only buffer window
    function automatic logic is_buf_window(input logic [12:0] addr);
        logic [2:0] win;
        win = addr[12:10];
        return (win >= BUF_WIN_LO) && (win <= BUF_WIN_HI);
    endfunction

endpackage

// File: rtl/data_read_axi_write_if.sv
// AXI4-Lite write channels (AW, W, B) of the data_read peripheral.
interface data_read_axi_write_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/data_read_axi_write.sv
// AXI4-Lite write slave for data_read: accepts AW/W in either order, owns the
// control register CR, and emits the CR.START and SR.C-clear pulses.
module data_read_axi_write
    import data_read_pkg::*;
#(
    parameter logic [3:0] C_CR_RESET = 4'b0000
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESETN,
    data_read_axi_write_if.slave        s_axi,
    output logic                        cr_start,
    output logic                        cr_enable,
    output logic [1:0]                  cr_mode,
    output logic                        sr_c_clr,
    output logic [31:0]                 cr_q
);

    wr_state_e   state_q, state_d;
    logic [12:0] awaddr_q, awaddr_d;
    logic [3:0]  wdata_q, wdata_d;
    logic        wstrb0_q, wstrb0_d;
    logic [3:1]  cr_bits_q, cr_bits_d;   // START is a pulse, so bit 0 is never stored
    logic [1:0]  bresp_q, bresp_d;
    logic        cr_start_q, cr_start_d;
    logic        sr_c_clr_q, sr_c_clr_d;

    logic aw_hs;
    logic w_hs;

    // Bus bits outside the decoded register map; collected here so they are
    // visibly intentionally ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{s_axi.awaddr[31:13], s_axi.wdata[31:4], s_axi.wstrb[3:1]};

    // Moore decode of readies and response valid from the current state
    always_comb begin
        s_axi.awready = (state_q == ST_IDLE) || (state_q == ST_WAIT_A);
        s_axi.wready  = (state_q == ST_IDLE) || (state_q == ST_WAIT_W);
        s_axi.bvalid  = (state_q == ST_RESP);
        s_axi.bresp   = bresp_q;
    end

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid  && s_axi.wready;

    // Next-state, address/data latching and register update decode
    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb0_d   = wstrb0_q;
        cr_bits_d  = cr_bits_q;
        bresp_d    = bresp_q;
        cr_start_d = 1'b0;
        sr_c_clr_d = 1'b0;

        // Capture each channel only on its own handshake; the bus is not
        // looked at again for this transaction afterwards.
        if (aw_hs) begin
            awaddr_d = s_axi.awaddr[12:0];
        end
        if (w_hs) begin
            wdata_d  = s_axi.wdata[3:0];
            wstrb0_d = s_axi.wstrb[0];
        end

        case (state_q)
            ST_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d = ST_WRITE;
                end else if (aw_hs) begin
                    state_d = ST_WAIT_W;
                end else if (w_hs) begin
                    state_d = ST_WAIT_A;
                end
            end
            ST_WAIT_W: begin
                if (w_hs) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WAIT_A: begin
                if (aw_hs) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Pulses are registered here so they appear in the first
                // RESP cycle only, however long BREADY is withheld.
                bresp_d = RESP_OKAY;
                if (is_buf_window(awaddr_q)) begin
                    bresp_d = RESP_SLVERR;
                end else if (wstrb0_q) begin
                    if (awaddr_q == AXI_ADDR_CR) begin
                        cr_bits_d  = wdata_q[CR_MODE_HI:CR_ENABLE_BIT];
                        cr_start_d = wdata_q[CR_START_BIT];
                    end else if (awaddr_q == AXI_ADDR_SR) begin
                        sr_c_clr_d = wdata_q[SR_C_BIT];
                    end
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (s_axi.bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latches, CR and pulse registers with asynchronous reset
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q    <= ST_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb0_q   <= 1'b0;
            cr_bits_q  <= C_CR_RESET[3:1];
            bresp_q    <= RESP_OKAY;
            cr_start_q <= 1'b0;
            sr_c_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb0_q   <= wstrb0_d;
            cr_bits_q  <= cr_bits_d;
            bresp_q    <= bresp_d;
            cr_start_q <= cr_start_d;
            sr_c_clr_q <= sr_c_clr_d;
        end
    end

    assign cr_start  = cr_start_q;
    assign sr_c_clr  = sr_c_clr_q;
    assign cr_enable = cr_bits_q[CR_ENABLE_BIT];
    assign cr_mode   = cr_bits_q[CR_MODE_HI:CR_MODE_LO];
    assign cr_q      = {28'd0, cr_mode, cr_enable, 1'b0};

endmodule

// File: tb/tb_data_read_axi_write.sv
// Directed bench for data_read_axi_write: hand-computed expectations for CR,
// SR-clear, buffer-window errors, strobe masking, BREADY stall and reset.
module tb_data_read_axi_write;

    logic        S_AXI_ACLK;
    logic        S_AXI_ARESETN;
    logic        cr_start;
    logic        cr_enable;
    logic [1:0]  cr_mode;
    logic        sr_c_clr;
    logic [31:0] cr_q;

    int n_total = 0;
    int n_bad   = 0;
    int start_cnt = 0;
    int clr_cnt   = 0;

    data_read_axi_write_if axi ();

    data_read_axi_write #(.C_CR_RESET(4'b0000)) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .s_axi         (axi),
        .cr_start      (cr_start),
        .cr_enable     (cr_enable),
        .cr_mode       (cr_mode),
        .sr_c_clr      (sr_c_clr),
        .cr_q          (cr_q)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    // Count pulse cycles so multi-cycle pulses are caught
    always @(posedge S_AXI_ACLK) begin
        if (cr_start) start_cnt <= start_cnt + 1;
        if (sr_c_clr) clr_cnt   <= clr_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge S_AXI_ACLK);
        #1;
    endtask

    // Present AW and W together for one cycle, then leave the FSM in WRITE
    task automatic send_both(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        axi.awaddr  = addr;
        axi.awvalid = 1'b1;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.wvalid  = 1'b1;
        tick;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
    endtask

    task automatic accept_resp;
        axi.bready = 1'b1;
        tick;
        axi.bready = 1'b0;
    endtask

    initial begin
        S_AXI_ARESETN = 1'b0;
        axi.awaddr  = '0;
        axi.awvalid = 1'b0;
        axi.wdata   = '0;
        axi.wstrb   = '0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        repeat (3) tick;

        // Reset state
        check_val("rst_awready", 32'(axi.awready), 32'd1);
        check_val("rst_wready",  32'(axi.wready),  32'd1);
        check_val("rst_bvalid",  32'(axi.bvalid),  32'd0);
        check_val("rst_bresp",   32'(axi.bresp),   32'd0);
        check_val("rst_pulses",  32'({cr_start, sr_c_clr}), 32'd0);
        check_val("rst_cr_q",    cr_q, 32'h0);
        S_AXI_ARESETN = 1'b1;
        tick;

        // CR write with AW and W in the same cycle
        send_both(32'h0000_0000, 32'h0000_000F, 4'b0001);
        check_val("t1_write_bvalid",  32'(axi.bvalid),  32'd0);
        check_val("t1_write_awready", 32'(axi.awready), 32'd0);
        tick;
        check_val("t1_bvalid",    32'(axi.bvalid), 32'd1);
        check_val("t1_bresp",     32'(axi.bresp),  32'd0);
        check_val("t1_cr_start",  32'(cr_start),   32'd1);
        check_val("t1_cr_enable", 32'(cr_enable),  32'd1);
        check_val("t1_cr_mode",   32'(cr_mode),    32'd3);
        check_val("t1_cr_q",      cr_q,            32'h0000_000E);
        tick;
        check_val("t1_start_gone", 32'(cr_start), 32'd0);
        accept_resp;
        check_val("t1_bvalid_done", 32'(axi.bvalid), 32'd0);
        check_val("t1_start_cnt",   32'(start_cnt),  32'd1);

        // SR clear with W three cycles ahead of AW
        axi.wdata  = 32'h0000_0001;
        axi.wstrb  = 4'b0001;
        axi.wvalid = 1'b1;
        tick;
        axi.wvalid = 1'b0;
        check_val("t2_wait_wready",  32'(axi.wready),  32'd0);
        check_val("t2_wait_awready", 32'(axi.awready), 32'd1);
        tick;
        tick;
        axi.awaddr  = 32'h0000_0004;
        axi.awvalid = 1'b1;
        tick;
        axi.awvalid = 1'b0;
        check_val("t2_write_awready", 32'(axi.awready), 32'd0);
        tick;
        check_val("t2_bvalid",   32'(axi.bvalid), 32'd1);
        check_val("t2_bresp",    32'(axi.bresp),  32'd0);
        check_val("t2_sr_c_clr", 32'(sr_c_clr),   32'd1);
        check_val("t2_cr_start", 32'(cr_start),   32'd0);
        check_val("t2_cr_q",     cr_q,            32'h0000_000E);
        accept_resp;
        check_val("t2_clr_cnt", 32'(clr_cnt), 32'd1);

        // Buffer window write -> SLVERR, no effect
        send_both(32'h0000_0800, 32'h0000_0005, 4'b0001);
        tick;
        check_val("t3_buf_bresp",  32'(axi.bresp), 32'd2);
        check_val("t3_buf_pulses", 32'({cr_start, sr_c_clr}), 32'd0);
        check_val("t3_buf_cr_q",   cr_q, 32'h0000_000E);
        accept_resp;

        // Unmapped offset -> OKAY, discarded
        send_both(32'h0000_1C00, 32'h0000_0005, 4'b0001);
        tick;
        check_val("t3_unmap_bresp", 32'(axi.bresp), 32'd0);
        check_val("t3_unmap_cr_q",  cr_q, 32'h0000_000E);
        accept_resp;

        // CR write with WSTRB[0]=0 -> OKAY, no change
        send_both(32'h0000_0000, 32'h0000_0001, 4'b1110);
        tick;
        check_val("t4_strb_bresp",  32'(axi.bresp), 32'd0);
        check_val("t4_strb_cr_q",   cr_q, 32'h0000_000E);
        check_val("t4_strb_start",  32'(cr_start), 32'd0);
        accept_resp;

        // CR write with BREADY withheld for 5 cycles
        send_both(32'h0000_0000, 32'h0000_0005, 4'b0001);
        tick;
        check_val("t4_stall_start", 32'(cr_start), 32'd1);
        check_val("t4_stall_cr_q",  cr_q, 32'h0000_0004);
        for (int i = 0; i < 5; i++) begin
            tick;
            check_val($sformatf("t4_stall_hold%0d", i),
                      32'({axi.bvalid, axi.bresp, cr_start}), 32'b1000);
        end
        accept_resp;
        check_val("t4_stall_start_cnt", 32'(start_cnt), 32'd2);

        // Reset while in RESP
        send_both(32'h0000_0000, 32'h0000_0007, 4'b0001);
        tick;
        check_val("t5_pre_rst_cr_q", cr_q, 32'h0000_0006);
        S_AXI_ARESETN = 1'b0;
        #1;
        check_val("t5_rst_bvalid",  32'(axi.bvalid),  32'd0);
        check_val("t5_rst_cr_q",    cr_q,             32'h0);
        check_val("t5_rst_awready", 32'(axi.awready), 32'd1);
        check_val("t5_rst_start",   32'(cr_start),    32'd0);
        tick;
        S_AXI_ARESETN = 1'b1;
        tick;
        send_both(32'h0000_0000, 32'h0000_000A, 4'b0001);
        tick;
        check_val("t5_after_bvalid", 32'(axi.bvalid), 32'd1);
        check_val("t5_after_bresp",  32'(axi.bresp),  32'd0);
        check_val("t5_after_cr_q",   cr_q,            32'h0000_000A);
        accept_resp;

        // Back-to-back writes with BREADY high: IDLE, WRITE, RESP
        axi.bready  = 1'b1;
        axi.awaddr  = 32'h0000_0000;
        axi.wdata   = 32'h0000_0002;
        axi.wstrb   = 4'b0001;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        tick;
        check_val("t6_c1_awready", 32'(axi.awready), 32'd0);
        tick;
        check_val("t6_c2_bvalid",  32'(axi.bvalid),  32'd1);
        tick;
        check_val("t6_c3_idle", 32'({axi.awready, axi.wready, axi.bvalid}), 32'b110);
        tick;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        check_val("t6_c4_write", 32'({axi.awready, axi.bvalid}), 32'b00);
        tick;
        check_val("t6_c5_bvalid", 32'(axi.bvalid), 32'd1);
        tick;
        axi.bready = 1'b0;
        check_val("t6_cr_q", cr_q, 32'h0000_0002);

        check_val("end_start_cnt", 32'(start_cnt), 32'd2);
        check_val("end_clr_cnt",   32'(clr_cnt),   32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
